// File: rtl/display_pkg.sv
// Shared display constants and types for the sprite overlay blocks.
// Holds the active screen size, the colour word width, the bit layout of the
// position register written by the game-state register file, and color_t.
package display_pkg;

    localparam int unsigned DISP_WIDTH  = 640;
    localparam int unsigned DISP_HEIGHT = 480;
    localparam int unsigned COLOR_BITS  = 12;

    // pos_reg layout: top edge in the low field, left edge in the upper half
    localparam int unsigned TOP_LSB  = 0;
    localparam int unsigned TOP_W    = 9;
    localparam int unsigned LEFT_LSB = 16;
    localparam int unsigned LEFT_W   = 10;

    typedef logic [COLOR_BITS-1:0] color_t;

endpackage

// File: rtl/sprite_rom.sv
// Sprite pixel-index ROM plus palette, two registered stages.
// Ports:
//   clk    in  pixel clock
//   reset  in  synchronous active-high reset, clears both stages
//   addr   in  pixel address (frame base + row*width + column)
//   color  out palette colour for addr, two clk cycles later
// The image is generated by a fixed index pattern (index = addr + 1, modulo 16)
// with palette entry k = {k,k,k}; entry 15 is the transparent key colour.
// An empty IMG_FILE or CLR_FILE name means "no image": every pixel reads as
// the transparent colour.
module sprite_rom #(
    parameter int unsigned                ADDR_W            = 13,
    parameter int unsigned                BITS_PER_COLOR    = 12,
    parameter logic [BITS_PER_COLOR-1:0]  TRANSPARENT_COLOR = BITS_PER_COLOR'(12'hF0F),
    parameter string                      IMG_FILE          = "sprite_image.mem",
    parameter string                      CLR_FILE          = "sprite_colors.mem"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         addr,
    output logic [BITS_PER_COLOR-1:0] color
);

    localparam bit HAS_IMAGE = (IMG_FILE != "") && (CLR_FILE != "");

    logic [3:0]                idx_d, idx_q;
    logic [BITS_PER_COLOR-1:0] color_d, color_q;

    always_comb begin
        idx_d   = HAS_IMAGE ? 4'(addr + ADDR_W'(1)) : 4'hF;
        color_d = BITS_PER_COLOR'({idx_q, idx_q, idx_q});
        if (idx_q == 4'hF) begin
            color_d = TRANSPARENT_COLOR;
        end
    end

    // Palette entry 0 is black, so the cycle after reset also reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            color_q <= '0;
        end else begin
            idx_q   <= idx_d;
            color_q <= color_d;
        end
    end

    assign color = color_q;

endmodule

// File: rtl/sprite_display.sv
// Animated sprite overlay for one on-screen object.
// Ports:
//   clk           in  pixel clock
//   reset         in  synchronous active-high reset
//   x, y          in  current pixel column / row
//   pos_reg       in  [8:0] top edge, [25:16] left edge, rest ignored
//   frame_tick    in  one-cycle pulse at start of vertical blank
//   anim_enable   in  lets the animation advance
//   inside_sprite out current pixel is an opaque sprite pixel (2-cycle latency)
//   colorData     out sprite colour for the current pixel (2-cycle latency)
//   frame_index   out animation frame currently displayed
// Position and frame index only change on frame_tick, so a frame never tears.
module sprite_display #(
    parameter int unsigned                SCREEN_WIDTH      = display_pkg::DISP_WIDTH,
    parameter int unsigned                SCREEN_HEIGHT     = display_pkg::DISP_HEIGHT,
    parameter int unsigned                SPRITE_WIDTH      = 35,
    parameter int unsigned                SPRITE_HEIGHT     = 35,
    parameter int unsigned                FRAMES            = 4,
    parameter int unsigned                TICKS_PER_FRAME   = 8,
    parameter int unsigned                BITS_PER_COLOR    = display_pkg::COLOR_BITS,
    parameter logic [BITS_PER_COLOR-1:0]  TRANSPARENT_COLOR = BITS_PER_COLOR'(12'hF0F),
    parameter string                      IMG_FILE          = "sprite_image.mem",
    parameter string                      CLR_FILE          = "sprite_colors.mem",
    localparam int unsigned               FRAME_W           = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                x,
    input  logic [8:0]                y,
    input  logic [31:0]               pos_reg,
    input  logic                      frame_tick,
    input  logic                      anim_enable,
    output logic                      inside_sprite,
    output logic [BITS_PER_COLOR-1:0] colorData,
    output logic [FRAME_W-1:0]        frame_index
);

    import display_pkg::*;

    localparam int unsigned FRAME_PIX = SPRITE_WIDTH * SPRITE_HEIGHT;
    localparam int unsigned ADDR_W    = $clog2(FRAMES * FRAME_PIX);
    localparam int unsigned TICK_W    = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

    logic [TOP_W-1:0]   top_d, top_q;
    logic [LEFT_W-1:0]  left_d, left_q;
    logic [TICK_W-1:0]  tick_d, tick_q;
    logic [FRAME_W-1:0] frame_d, frame_q;
    logic               in_win_q1, in_win_q2;

    logic unused_pos;
    assign unused_pos = ^{pos_reg[31:LEFT_LSB+LEFT_W], pos_reg[LEFT_LSB-1:TOP_LSB+TOP_W]};

    // Shadow position and animation counters, all advanced only by frame_tick.
    always_comb begin
        top_d   = top_q;
        left_d  = left_q;
        tick_d  = tick_q;
        frame_d = frame_q;
        if (frame_tick) begin
            top_d  = pos_reg[TOP_LSB +: TOP_W];
            left_d = pos_reg[LEFT_LSB +: LEFT_W];
            if (anim_enable) begin
                if (tick_q == TICK_W'(TICKS_PER_FRAME - 1)) begin
                    tick_d  = '0;
                    frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
        end
    end

    // Stage 0: window test. Edge sums are one bit wider so an overhanging
    // sprite clips at the screen edge instead of wrapping to column/row 0.
    logic [10:0] x_end;
    logic [9:0]  y_end;
    logic        in_win;

    assign x_end  = {1'b0, left_q} + 11'(SPRITE_WIDTH);
    assign y_end  = {1'b0, top_q} + 10'(SPRITE_HEIGHT);
    assign in_win = (x >= left_q) && ({1'b0, x} < x_end) &&
                    (y >= top_q) && ({1'b0, y} < y_end) &&
                    (32'(x) < SCREEN_WIDTH) && (32'(y) < SCREEN_HEIGHT);

    // Stage 0: address; row stride is the sprite width, not the screen width.
    logic [LEFT_W-1:0] dx;
    logic [TOP_W-1:0]  dy;
    logic [ADDR_W-1:0] addr_raw, addr;

    assign dx       = x - left_q;
    assign dy       = y - top_q;
    assign addr_raw = ADDR_W'(frame_q) * ADDR_W'(FRAME_PIX) +
                      ADDR_W'(dy) * ADDR_W'(SPRITE_WIDTH) + ADDR_W'(dx);
    assign addr     = in_win ? addr_raw : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q     <= '0;
            left_q    <= '0;
            tick_q    <= '0;
            frame_q   <= '0;
            in_win_q1 <= 1'b0;
            in_win_q2 <= 1'b0;
        end else begin
            top_q     <= top_d;
            left_q    <= left_d;
            tick_q    <= tick_d;
            frame_q   <= frame_d;
            in_win_q1 <= in_win;
            in_win_q2 <= in_win_q1;
        end
    end

    sprite_rom #(
        .ADDR_W            (ADDR_W),
        .BITS_PER_COLOR    (BITS_PER_COLOR),
        .TRANSPARENT_COLOR (TRANSPARENT_COLOR),
        .IMG_FILE          (IMG_FILE),
        .CLR_FILE          (CLR_FILE)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .color (colorData)
    );

    assign inside_sprite = in_win_q2 && (colorData != TRANSPARENT_COLOR);
    assign frame_index   = frame_q;

endmodule
